ram_arbiter: RTL and testbench

//   Shares the single DPI-backed RAM port (RAMCtrl: raddr/rdata/waddr/wdata/wmask/wen, 64b) between IFU and LSU.
//   Per-requester valid/ready request and response channels; round-robin grant; one transaction in flight.

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/rr_arb2.sv | 20 ++
 rtl/ram_arbiter.sv | 93 +++++++++
 tb/tb_ram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and requester encodings for the RAM port arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - IFU/LSU request-response channels plus the RAMCtrl port
interface ram_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_resp_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [DATA_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_rdata;

    logic [ADDR_W-1:0] ram_raddr;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_wmask;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;

    // master: core stages and RAMCtrl side; slave: the arbiter
    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        output ram_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  ram_raddr, ram_waddr, ram_wdata, ram_wmask, ram_wen
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        input  ram_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output ram_raddr, ram_waddr, ram_wdata, ram_wmask, ram_wen
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin grant
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[REQ_IFU] && (!req_i[REQ_LSU] || last_i == REQ_LSU)) begin
            gnt_o[REQ_IFU] = 1'b1;
        end else if (req_i[REQ_LSU]) begin
            gnt_o[REQ_LSU] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one RAM port between IFU and LSU, one transaction in flight
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic              owner_q;
    logic              last_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wmask_q;

    logic [1:0]        gnt;
    logic              accept;
    logic              resp_hs;
    logic              in_resp;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req_i  ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign accept  = (state_q == IDLE) && (gnt != 2'b00);
    assign resp_hs = (owner_q == REQ_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_IFU;
            last_q  <= REQ_LSU;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= gnt[REQ_LSU];
                last_q  <= gnt[REQ_LSU];
                if (gnt[REQ_LSU]) begin
                    addr_q  <= bus.lsu_req_addr;
                    wen_q   <= bus.lsu_req_wen;
                    wdata_q <= bus.lsu_req_wdata;
                    wmask_q <= bus.lsu_req_wmask;
                end else begin
                    addr_q  <= bus.ifu_req_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
        end
    end

    // Every control output is forced low while reset is high, whatever state_q holds.
    assign in_resp   = !reset && (state_q == RESP);
    assign resp_data = wen_q ? '0 : bus.ram_rdata;

    assign bus.ifu_req_ready  = !reset && (state_q == IDLE) && gnt[REQ_IFU];
    assign bus.lsu_req_ready  = !reset && (state_q == IDLE) && gnt[REQ_LSU];
    assign bus.ifu_resp_valid = in_resp && (owner_q == REQ_IFU);
    assign bus.lsu_resp_valid = in_resp && (owner_q == REQ_LSU);
    assign bus.ifu_resp_rdata = bus.ifu_resp_valid ? resp_data : '0;
    assign bus.lsu_resp_rdata = bus.lsu_resp_valid ? resp_data : '0;

    // Address held in every state so a stalled read keeps returning the same word.
    assign bus.ram_raddr = addr_q;
    assign bus.ram_waddr = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wmask = wmask_q;
    assign bus.ram_wen   = !reset && (state_q == ISSUE) && wen_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ram_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    // RAM stub: registered read, masked write on the edge where ram_wen is high
    logic [63:0] ram_mem [logic [63:0]];
    function automatic logic [63:0] ram_rd(input logic [63:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction
    always @(posedge clock) begin
        bus.ram_rdata <= ram_rd(bus.ram_raddr);
        if (bus.ram_wen)
            ram_mem[bus.ram_waddr] = (ram_rd(bus.ram_waddr) & ~bus.ram_wmask) | (bus.ram_wdata & bus.ram_wmask);
    end

    // Transaction-level reference: memory image, one outstanding txn, whose turn it is on a tie
    logic [63:0] ref_mem [logic [63:0]];
    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    bit          busy = 0;
    int          age = 0;
    bit          own = 0;
    bit          is_wr = 0;
    bit          last_lsu = 1;
    logic [63:0] m_addr, m_wdata, m_wmask, m_exp;
    bit          ifu_acc = 0, lsu_acc = 0;
    int          ifu_done = 0, lsu_done = 0, wen_cycles = 0;
    logic [63:0] ifu_last = '0, lsu_last = '0;
    bit          grant_log [$];

    task automatic sample_and_check();
        bit g_ifu, g_lsu;
        ifu_acc = 0;
        lsu_acc = 0;
        if (bus.ram_wen) wen_cycles++;
        if (reset) begin
            check("rst_ifu_rdy",   64'(bus.ifu_req_ready),  64'd0);
            check("rst_lsu_rdy",   64'(bus.lsu_req_ready),  64'd0);
            check("rst_ifu_rv",    64'(bus.ifu_resp_valid), 64'd0);
            check("rst_lsu_rv",    64'(bus.lsu_resp_valid), 64'd0);
            check("rst_wen",       64'(bus.ram_wen),        64'd0);
            check("rst_lsu_rdata", bus.lsu_resp_rdata,      64'd0);
            busy     = 0;
            last_lsu = 1;
        end else if (!busy) begin
            g_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu);
            g_lsu = bus.lsu_req_valid && !g_ifu;
            check("idle_ifu_rdy", 64'(bus.ifu_req_ready),  64'(g_ifu));
            check("idle_lsu_rdy", 64'(bus.lsu_req_ready),  64'(g_lsu));
            check("idle_ifu_rv",  64'(bus.ifu_resp_valid), 64'd0);
            check("idle_lsu_rv",  64'(bus.lsu_resp_valid), 64'd0);
            check("idle_wen",     64'(bus.ram_wen),        64'd0);
            if (g_ifu || g_lsu) begin
                busy     = 1;
                age      = 1;
                own      = g_lsu;
                last_lsu = g_lsu;
                grant_log.push_back(g_lsu);
                ifu_acc  = g_ifu;
                lsu_acc  = g_lsu;
                if (g_lsu) begin
                    is_wr   = bus.lsu_req_wen;
                    m_addr  = bus.lsu_req_addr;
                    m_wdata = bus.lsu_req_wdata;
                    m_wmask = bus.lsu_req_wmask;
                end else begin
                    is_wr   = 0;
                    m_addr  = bus.ifu_req_addr;
                    m_wdata = '0;
                    m_wmask = '0;
                end
            end
        end else if (age == 1) begin
            check("iss_ifu_rdy", 64'(bus.ifu_req_ready),  64'd0);
            check("iss_lsu_rdy", 64'(bus.lsu_req_ready),  64'd0);
            check("iss_ifu_rv",  64'(bus.ifu_resp_valid), 64'd0);
            check("iss_lsu_rv",  64'(bus.lsu_resp_valid), 64'd0);
            check("iss_wen",     64'(bus.ram_wen),        64'(is_wr));
            check("iss_raddr",   bus.ram_raddr,           m_addr);
            check("iss_waddr",   bus.ram_waddr,           m_addr);
            check("iss_wdata",   bus.ram_wdata,           m_wdata);
            check("iss_wmask",   bus.ram_wmask,           m_wmask);
            if (is_wr) ref_mem[m_addr] = (ref_rd(m_addr) & ~m_wmask) | (m_wdata & m_wmask);
            m_exp = is_wr ? 64'd0 : ref_rd(m_addr);
            age = 2;
        end else begin
            check("rsp_ifu_rdy", 64'(bus.ifu_req_ready),  64'd0);
            check("rsp_lsu_rdy", 64'(bus.lsu_req_ready),  64'd0);
            check("rsp_wen",     64'(bus.ram_wen),        64'd0);
            check("rsp_ifu_rv",  64'(bus.ifu_resp_valid), 64'(!own));
            check("rsp_lsu_rv",  64'(bus.lsu_resp_valid), 64'(own));
            check("rsp_raddr",   bus.ram_raddr,           m_addr);
            if (own) check("rsp_lsu_rdata", bus.lsu_resp_rdata, m_exp);
            else     check("rsp_ifu_rdata", bus.ifu_resp_rdata, m_exp);
            if (own ? bus.lsu_resp_ready : bus.ifu_resp_ready) begin
                busy = 0;
                if (own) begin lsu_done++; lsu_last = bus.lsu_resp_rdata; end
                else     begin ifu_done++; ifu_last = bus.ifu_resp_rdata; end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        sample_and_check();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && busy; i++) cycle();
        check("drain_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        bus.ifu_req_valid = 0;
        bus.lsu_req_valid = 0;
        repeat (n) cycle();
        reset = 0;
    endtask

    task automatic lsu_txn(input bit wr, input logic [63:0] a, input logic [63:0] d,
                           input logic [63:0] m, output logic [63:0] r);
        int d0;
        bus.lsu_req_valid  = 1;
        bus.lsu_req_wen    = wr;
        bus.lsu_req_addr   = a;
        bus.lsu_req_wdata  = d;
        bus.lsu_req_wmask  = m;
        bus.lsu_resp_ready = 1;
        d0 = lsu_done;
        lsu_acc = 0;
        for (int i = 0; i < 20 && !lsu_acc; i++) cycle();
        check("lsu_acc_timeout", 64'(lsu_acc), 64'd1);
        bus.lsu_req_valid = 0;
        for (int i = 0; i < 20 && lsu_done == d0; i++) cycle();
        check("lsu_resp_timeout", 64'(lsu_done - d0), 64'd1);
        r = lsu_last;
    endtask

    function automatic logic [63:0] rand_addr();
        return 64'h8000_0000 + 64'(8 * $urandom_range(0, 7));
    endfunction

    task automatic drive_rand();
        if (!bus.ifu_req_valid || ifu_acc) begin
            bus.ifu_req_valid = ($urandom_range(0, 2) != 0);
            bus.ifu_req_addr  = rand_addr();
        end else if ($urandom_range(0, 7) == 0) begin
            bus.ifu_req_valid = 0;
        end
        if (!bus.lsu_req_valid || lsu_acc) begin
            bus.lsu_req_valid = ($urandom_range(0, 2) != 0);
            bus.lsu_req_addr  = rand_addr();
            bus.lsu_req_wen   = $urandom_range(0, 1) == 1;
            bus.lsu_req_wdata = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       bus.lsu_req_wmask = '1;
                1:       bus.lsu_req_wmask = 64'h0000_0000_FFFF_FFFF;
                default: bus.lsu_req_wmask = {$urandom, $urandom};
            endcase
        end else if ($urandom_range(0, 7) == 0) begin
            bus.lsu_req_valid = 0;
        end
        bus.ifu_resp_ready = ($urandom_range(0, 2) != 0);
        bus.lsu_resp_ready = ($urandom_range(0, 2) != 0);
        reset = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] r, h;
        int d0, w0;
        bus.ifu_req_valid = 0;  bus.ifu_req_addr = '0;  bus.ifu_resp_ready = 0;
        bus.lsu_req_valid = 0;  bus.lsu_req_addr = '0;  bus.lsu_req_wen = 0;
        bus.lsu_req_wdata = '0; bus.lsu_req_wmask = '0; bus.lsu_resp_ready = 0;
        do_reset(3);

        // IFU read alone: ready same cycle, no write strobe, RAM word back at N+2
        w0 = wen_cycles;
        d0 = ifu_done;
        bus.ifu_req_valid  = 1;
        bus.ifu_req_addr   = 64'h8000_0000;
        bus.ifu_resp_ready = 1;
        cycle();
        check("ifu_first_acc", 64'(ifu_acc), 64'd1);
        bus.ifu_req_valid = 0;
        for (int i = 0; i < 20 && ifu_done == d0; i++) cycle();
        check("ifu_rdata", ifu_last, init_word(64'h8000_0000));
        check("ifu_no_wen", 64'(wen_cycles - w0), 64'd0);

        // LSU write: one strobe cycle, ack data zero
        w0 = wen_cycles;
        lsu_txn(1, 64'h8000_0010, 64'hDEAD_BEEF, 64'hFFFF_FFFF, r);
        check("wr_wen_cycles", 64'(wen_cycles - w0), 64'd1);
        check("wr_ack_rdata", r, 64'd0);

        // Both valid from reset: IFU first, then alternate
        do_reset(2);
        grant_log.delete();
        bus.ifu_req_valid  = 1; bus.ifu_req_addr = 64'h8000_0100;
        bus.lsu_req_valid  = 1; bus.lsu_req_wen = 0; bus.lsu_req_addr = 64'h8000_0010;
        bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
        repeat (14) cycle();
        bus.ifu_req_valid = 0;
        bus.lsu_req_valid = 0;
        drain();
        check("rr_count_ge4", 64'(grant_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("rr_order", 64'(grant_log[i]), 64'(i % 2));

        // LSU read stalled 5 cycles while IFU waits
        bus.lsu_req_valid = 1; bus.lsu_req_wen = 0; bus.lsu_req_addr = 64'h8000_0010;
        bus.lsu_resp_ready = 0;
        lsu_acc = 0;
        for (int i = 0; i < 20 && !lsu_acc; i++) cycle();
        check("stall_acc", 64'(lsu_acc), 64'd1);
        bus.lsu_req_valid = 0;
        bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_0008;
        cycle();
        h = bus.lsu_resp_rdata;
        check("stall_rdata0", h, (init_word(64'h8000_0010) & ~64'hFFFF_FFFF) | 64'hDEAD_BEEF);
        repeat (5) begin
            cycle();
            check("stall_rv",      64'(bus.lsu_resp_valid), 64'd1);
            check("stall_rdata",   bus.lsu_resp_rdata,      h);
            check("stall_ifu_rdy", 64'(bus.ifu_req_ready),  64'd0);
        end
        bus.ifu_req_valid  = 0;
        bus.lsu_resp_ready = 1;
        drain();

        // Reset during ISSUE of a write: no strobe, no response, write lost
        d0 = lsu_done;
        w0 = wen_cycles;
        bus.lsu_req_valid = 1; bus.lsu_req_wen = 1; bus.lsu_req_addr = 64'h8000_0020;
        bus.lsu_req_wdata = 64'h55; bus.lsu_req_wmask = '1;
        lsu_acc = 0;
        for (int i = 0; i < 20 && !lsu_acc; i++) cycle();
        bus.lsu_req_valid = 0;
        reset = 1;
        #2;
        check("rst_iss_wen_now", 64'(bus.ram_wen), 64'd0);
        cycle();
        reset = 0;
        repeat (4) cycle();
        check("rst_iss_no_resp", 64'(lsu_done - d0), 64'd0);
        check("rst_iss_no_wen",  64'(wen_cycles - w0), 64'd0);
        lsu_txn(0, 64'h8000_0020, '0, '0, r);
        check("rst_iss_mem", r, init_word(64'h8000_0020));

        // Write then read back, full and partial mask
        lsu_txn(1, 64'h8000_0030, 64'h1234, '1, r);
        lsu_txn(0, 64'h8000_0030, '0, '0, r);
        check("rd_after_wr", r, 64'h1234);
        lsu_txn(1, 64'h8000_0030, '1, 64'hFF00, r);
        lsu_txn(0, 64'h8000_0030, '0, '0, r);
        check("rd_after_mask", r, 64'hFF34);

        // Randomized traffic against the model
        do_reset(1);
        repeat (2000) begin
            drive_rand();
            cycle();
        end
        reset = 0;
        bus.ifu_req_valid = 0;
        bus.lsu_req_valid = 0;
        bus.ifu_resp_ready = 1;
        bus.lsu_resp_ready = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
